// File: rtl/dm_pkg.sv
// Shared data-memory definitions: DMType encodings and arbiter state.
package dm_pkg;

    // DMType encodings shared by SCPU, dm and the arbiter
    localparam logic [2:0] dm_word              = 3'b000;
    localparam logic [2:0] dm_halfword          = 3'b001;
    localparam logic [2:0] dm_halfword_unsigned = 3'b010;
    localparam logic [2:0] dm_byte              = 3'b011;
    localparam logic [2:0] dm_byte_unsigned     = 3'b100;

    // Arbiter ownership state
    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } arb_state_e;

endpackage : dm_pkg

// File: rtl/dm_arbiter.sv
// Shares the dm port between the CPU load/store path and the debug/loader port.
module dm_arbiter
    import dm_pkg::*;
#(
    parameter int unsigned ADDR_W     = 9,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [2:0]        cpu_type,
    input  logic [31:0]       cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_stall,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [2:0]        dbg_type,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [31:0]       dbg_wdata,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [31:0]       dbg_rdata,
    input  logic              halt_req,
    output logic              halt_ack,
    output logic              dm_we,
    output logic [2:0]        dm_type,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [31:0]       dm_din,
    input  logic [31:0]       dm_dout
);

    localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    arb_state_e       state;
    arb_state_e       state_next;
    logic [CNT_W-1:0] starve_cnt;
    logic [CNT_W-1:0] starve_cnt_next;
    logic             cpu_gnt;
    logic             rvalid_q;
    logic [31:0]      rdata_q;

    // Only the low ADDR_W bits of the CPU byte address reach dm
    logic unused_cpu_addr;
    assign unused_cpu_addr = ^cpu_addr[31:ADDR_W];

    // Arbitration, starvation counting, next state and dm mux
    always_comb begin
        state_next      = state;
        starve_cnt_next = '0;
        dbg_gnt         = 1'b0;
        cpu_gnt         = 1'b0;
        dm_we           = 1'b0;
        dm_type         = '0;
        dm_addr         = '0;
        dm_din          = '0;

        case (state)
            RUN: begin
                dbg_gnt = dbg_req & (~cpu_req | (starve_cnt == CNT_MAX));
                cpu_gnt = cpu_req & ~dbg_gnt;
                if (dbg_req && !dbg_gnt) begin
                    starve_cnt_next = (starve_cnt == CNT_MAX) ? starve_cnt
                                                              : starve_cnt + CNT_W'(1);
                end
                if (halt_req) begin
                    state_next = HALTED;
                end
            end
            HALTED: begin
                dbg_gnt = dbg_req;
                if (!halt_req) begin
                    state_next = RUN;
                end
            end
            default: begin
                state_next = RUN;
            end
        endcase

        // No access may reach dm while reset is asserted
        if (reset) begin
            dbg_gnt = 1'b0;
            cpu_gnt = 1'b0;
        end

        cpu_stall = cpu_req & ~cpu_gnt;

        if (dbg_gnt) begin
            dm_we   = dbg_we;
            dm_type = dbg_type;
            dm_addr = dbg_addr;
            dm_din  = dbg_wdata;
        end else if (cpu_gnt) begin
            dm_we   = cpu_we;
            dm_type = cpu_type;
            dm_addr = cpu_addr[ADDR_W-1:0];
            dm_din  = cpu_wdata;
        end
    end

    // State, starvation counter and debug read-return registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= RUN;
            starve_cnt <= '0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
        end else begin
            state      <= state_next;
            starve_cnt <= starve_cnt_next;
            rvalid_q   <= dbg_gnt & ~dbg_we;
            if (dbg_gnt && !dbg_we) begin
                rdata_q <= dm_dout;
            end
        end
    end

    // Registered status, masked while reset is held so reset always wins
    assign halt_ack   = (state == HALTED) & ~reset;
    assign dbg_rvalid = rvalid_q & ~reset;
    assign dbg_rdata  = reset ? '0 : rdata_q;
    assign cpu_rdata  = dm_dout;

endmodule : dm_arbiter

// File: tb/tb_dm_arbiter.sv
// Self-checking bench for dm_arbiter with a behavioural dm and reference model.
module tb_dm_arbiter;

    localparam int unsigned ADDR_W     = 9;
    localparam int unsigned STARVE_MAX = 4;
    localparam int unsigned DEPTH      = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              reset;
    logic              cpu_req;
    logic              cpu_we;
    logic [2:0]        cpu_type;
    logic [31:0]       cpu_addr;
    logic [31:0]       cpu_wdata;
    logic [31:0]       cpu_rdata;
    logic              cpu_stall;
    logic              dbg_req;
    logic              dbg_we;
    logic [2:0]        dbg_type;
    logic [ADDR_W-1:0] dbg_addr;
    logic [31:0]       dbg_wdata;
    logic              dbg_gnt;
    logic              dbg_rvalid;
    logic [31:0]       dbg_rdata;
    logic              halt_req;
    logic              halt_ack;
    logic              dm_we;
    logic [2:0]        dm_type;
    logic [ADDR_W-1:0] dm_addr;
    logic [31:0]       dm_din;
    logic [31:0]       dm_dout;
    logic              mem_init;

    int compared   = 0;
    int mismatched = 0;

    dm_arbiter #(.ADDR_W(ADDR_W), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_type(cpu_type), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_type(dbg_type), .dbg_addr(dbg_addr),
        .dbg_wdata(dbg_wdata), .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid),
        .dbg_rdata(dbg_rdata), .halt_req(halt_req), .halt_ack(halt_ack),
        .dm_we(dm_we), .dm_type(dm_type), .dm_addr(dm_addr), .dm_din(dm_din),
        .dm_dout(dm_dout)
    );

    always #5 clk = ~clk;

    // Stand-in dm: combinational read, write on the rising edge
    logic [31:0] dm_mem [DEPTH];
    assign dm_dout = dm_mem[dm_addr];
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < int'(DEPTH); i++) dm_mem[i] <= 32'(i) * 32'h9E37_79B1;
        end else if (dm_we) begin
            dm_mem[dm_addr] <= dm_din;
        end
    end

    // Reference model state
    logic [31:0] ref_mem [DEPTH];
    bit          m_halted;
    int          m_wait;
    bit          m_rvalid;
    logic [31:0] m_rdata;
    bit          e_dgnt;
    bit          e_cgnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Predict this cycle's outputs and compare against the DUT
    task automatic eval();
        logic [31:0] ea;
        #1;
        if (reset) begin
            e_dgnt = 1'b0;
            e_cgnt = 1'b0;
        end else if (m_halted) begin
            e_dgnt = dbg_req;
            e_cgnt = 1'b0;
        end else begin
            e_dgnt = dbg_req && (!cpu_req || m_wait >= int'(STARVE_MAX));
            e_cgnt = cpu_req && !e_dgnt;
        end
        chk("dbg_gnt", 32'(dbg_gnt), 32'(e_dgnt));
        chk("cpu_stall", 32'(cpu_stall), 32'(cpu_req && !e_cgnt));
        if (e_dgnt) begin
            chk("dm_we", 32'(dm_we), 32'(dbg_we));
            chk("dm_type", 32'(dm_type), 32'(dbg_type));
            chk("dm_addr", 32'(dm_addr), 32'(dbg_addr));
            if (dbg_we) chk("dm_din", dm_din, dbg_wdata);
        end else if (e_cgnt) begin
            ea = 32'(cpu_addr[ADDR_W-1:0]);
            chk("dm_we", 32'(dm_we), 32'(cpu_we));
            chk("dm_type", 32'(dm_type), 32'(cpu_type));
            chk("dm_addr", 32'(dm_addr), ea);
            if (cpu_we) chk("dm_din", dm_din, cpu_wdata);
            else        chk("cpu_rdata", cpu_rdata, ref_mem[ea]);
        end else begin
            chk("dm_we", 32'(dm_we), 32'd0);
            chk("dm_type", 32'(dm_type), 32'd0);
            chk("dm_addr", 32'(dm_addr), 32'd0);
            chk("dm_din", dm_din, 32'd0);
        end
        chk("halt_ack", 32'(halt_ack), reset ? 32'd0 : 32'(m_halted));
        chk("dbg_rvalid", 32'(dbg_rvalid), reset ? 32'd0 : 32'(m_rvalid));
        chk("dbg_rdata", dbg_rdata, reset ? 32'd0 : m_rdata);
    endtask

    // Clock edge: advance the reference model with the inputs held this cycle
    task automatic adv();
        @(posedge clk);
        if (reset) begin
            m_halted = 1'b0;
            m_wait   = 0;
            m_rvalid = 1'b0;
            m_rdata  = '0;
        end else begin
            m_rvalid = e_dgnt && !dbg_we;
            if (m_rvalid) m_rdata = ref_mem[dbg_addr];
            if (e_dgnt && dbg_we) ref_mem[dbg_addr] = dbg_wdata;
            if (e_cgnt && cpu_we) ref_mem[cpu_addr[ADDR_W-1:0]] = cpu_wdata;
            if (m_halted || !dbg_req || e_dgnt) m_wait = 0;
            else if (m_wait < int'(STARVE_MAX)) m_wait++;
            m_halted = halt_req;
        end
        @(negedge clk);
    endtask

    task automatic cpu_set(input bit req, input bit we, input logic [31:0] a, input logic [31:0] d);
        cpu_req = req; cpu_we = we; cpu_addr = a; cpu_wdata = d; cpu_type = 3'b000;
    endtask

    task automatic dbg_set(input bit req, input bit we, input logic [ADDR_W-1:0] a, input logic [31:0] d);
        dbg_req = req; dbg_we = we; dbg_addr = a; dbg_wdata = d; dbg_type = 3'b000;
    endtask

    initial begin
        bit hold;
        bit halt_lvl;

        for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = 32'(i) * 32'h9E37_79B1;
        m_halted = 0; m_wait = 0; m_rvalid = 0; m_rdata = '0;

        // Reset cycle with both requesters active: nothing granted
        reset = 1'b1; mem_init = 1'b1; halt_req = 1'b0;
        cpu_set(1, 1, 32'h10, 32'hFFFF_FFFF);
        dbg_set(1, 1, 9'h10, 32'hFFFF_FFFF);
        eval(); chk("rst_dm_we", 32'(dm_we), 32'd0); adv();
        mem_init = 1'b0;
        eval(); adv();

        // CPU store then load, same-cycle grant
        reset = 1'b0;
        dbg_set(0, 0, '0, '0);
        cpu_set(1, 1, 32'h10, 32'h1234_5678);
        eval(); chk("st_stall", 32'(cpu_stall), 32'd0); chk("st_we", 32'(dm_we), 32'd1); adv();
        cpu_set(1, 0, 32'h10, 32'h0);
        eval(); chk("ld_rdata", cpu_rdata, 32'h1234_5678); adv();

        // Starvation guard: debug read granted in the 5th cycle of contention
        dbg_set(1, 0, 9'h10, '0);
        for (int i = 0; i < 6; i++) begin
            if (i == 5) dbg_set(0, 0, '0, '0);
            eval();
            chk("starve_gnt", 32'(dbg_gnt), (i == 4) ? 32'd1 : 32'd0);
            chk("starve_stall", 32'(cpu_stall), (i == 4) ? 32'd1 : 32'd0);
            if (i == 5) chk("starve_rdata", dbg_rdata, 32'h1234_5678);
            adv();
        end

        // Halt handshake with debug write, then CPU reads it back
        halt_req = 1'b1;
        eval(); chk("halt_n_ack", 32'(halt_ack), 32'd0); adv();
        eval(); chk("halt_ack", 32'(halt_ack), 32'd1); chk("halt_stall", 32'(cpu_stall), 32'd1); adv();
        dbg_set(1, 1, 9'h20, 32'hDEAD_BEEF);
        eval(); chk("halt_dgnt", 32'(dbg_gnt), 32'd1); adv();
        dbg_set(0, 0, '0, '0);
        halt_req = 1'b0;
        cpu_set(1, 0, 32'h20, 32'h0);
        eval(); chk("unhalt_stall", 32'(cpu_stall), 32'd1); adv();
        eval(); chk("unhalt_rdata", cpu_rdata, 32'hDEAD_BEEF); adv();

        // Contention below the starvation limit: CPU wins
        cpu_set(1, 1, 32'h30, 32'h0000_0055);
        dbg_set(1, 0, 9'h40, '0);
        eval(); chk("cont_dgnt", 32'(dbg_gnt), 32'd0); chk("cont_we", 32'(dm_we), 32'd1); adv();
        cpu_set(0, 0, 32'h0, 32'h0);
        eval(); chk("rd_gnt", 32'(dbg_gnt), 32'd1); adv();

        // Reset right after a granted read suppresses the return
        dbg_set(0, 0, '0, '0);
        reset = 1'b1;
        eval(); chk("rst_rvalid", 32'(dbg_rvalid), 32'd0); chk("rst_rdata", dbg_rdata, 32'd0); adv();
        reset = 1'b0;

        // Idle: dm port parked at zero
        eval(); chk("idle_din", dm_din, 32'd0); chk("idle_stall", 32'(cpu_stall), 32'd0); adv();

        // Randomized traffic honouring the debug hold protocol
        hold = 0; halt_lvl = 0;
        for (int n = 0; n < 600; n++) begin
            reset = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 11) == 0) halt_lvl = ~halt_lvl;
            halt_req = halt_lvl;
            cpu_req   = ($urandom_range(0, 3) != 0);
            cpu_we    = 1'($urandom_range(0, 1));
            cpu_type  = 3'($urandom_range(0, 4));
            cpu_addr  = {$urandom_range(0, 65535), 7'd0, 7'($urandom_range(0, 127)), 2'b00};
            cpu_wdata = $urandom;
            if (!hold) begin
                dbg_req   = ($urandom_range(0, 2) != 0);
                dbg_we    = 1'($urandom_range(0, 1));
                dbg_type  = 3'($urandom_range(0, 4));
                dbg_addr  = {7'($urandom_range(0, 127)), 2'b00};
                dbg_wdata = $urandom;
            end
            eval();
            hold = dbg_req && !e_dgnt;
            adv();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule : tb_dm_arbiter
